// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and access-size helper for the load/store stage.
package mem_stage_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Bytes touched by an access; illegal encodings report 1 and are rejected elsewhere.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_H, FUNCT3_HU: access_size = 3'd4 >> 1;
            FUNCT3_W:            access_size = 3'd4;
            default:             access_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request, memory data-port and response bundle for mem_stage.
// slave = the stage itself, master = execute/memory/writeback environment.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [RD_W-1:0]   req_rd;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write;
    logic              mem_is_read;
    logic              mem_is_write;
    logic [2:0]        mem_mode;
    logic [31:0]       mem_read;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [RD_W-1:0]   resp_rd;
    logic              resp_is_load;
    logic              resp_fault;

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_address, mem_write, mem_is_read, mem_is_write, mem_mode,
        input  mem_read,
        input  resp_ready,
        output resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
    );

    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_address, mem_write, mem_is_read, mem_is_write, mem_mode,
        output mem_read,
        output resp_ready,
        input  resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
    );
endinterface

// File: rtl/mem_stage_check.sv
// Combinational legality check: funct3, alignment and range of one request.
// Defining MEM_STAGE_MISALIGN_EN removes the alignment term (memory handles byte addressing).
module mem_stage_check
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    output logic              fault
);
    logic            bad_f3;
    logic            misalign;
    logic            out_of_range;
    logic [ADDR_W:0] last_byte;

    always_comb begin
        bad_f3 = 1'b0;
        if (is_load) begin
            case (funct3)
                FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU: bad_f3 = 1'b0;
                default:                                            bad_f3 = 1'b1;
            endcase
        end else if (is_store) begin
            case (funct3)
                FUNCT3_B, FUNCT3_H, FUNCT3_W: bad_f3 = 1'b0;
                default:                      bad_f3 = 1'b1;
            endcase
        end
    end

`ifdef MEM_STAGE_MISALIGN_EN
    assign misalign = 1'b0;
`else
    always_comb begin
        case (funct3)
            FUNCT3_H, FUNCT3_HU: misalign = addr[0];
            FUNCT3_W:            misalign = (addr[1:0] != 2'b00);
            default:             misalign = 1'b0;
        endcase
    end
`endif

    // One extra bit so accesses near the top of the address space cannot wrap to a legal address.
    assign last_byte    = {1'b0, addr} + (ADDR_W+1)'(access_size(funct3)) - (ADDR_W+1)'(1);
    assign out_of_range = (last_byte >= (ADDR_W+1)'(MEM_BYTES));

    assign fault = (is_load && is_store) ||
                   ((is_load || is_store) && (bad_f3 || misalign || out_of_range));

endmodule

// File: rtl/mem_stage.sv
// Load/store stage in front of the data memory: accept, check, one-cycle access, respond.
// Build option MEM_STAGE_MISALIGN_EN (in mem_stage_check) lets misaligned accesses through.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32,
    parameter int RD_W      = 5
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);
    state_t            state, state_nxt;
    logic              fault;
    logic              accept;
    logic              ld_q, st_q, fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        mode_q;
    logic [31:0]       data_q;
    logic [RD_W-1:0]   rd_q;

    mem_stage_check #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_check (
        .is_load  (bus.req_is_load),
        .is_store (bus.req_is_store),
        .funct3   (bus.req_funct3),
        .addr     (bus.req_addr),
        .fault    (fault)
    );

    // Requests that are neither load nor store are consumed without leaving IDLE.
    assign accept = (state == ST_IDLE) && bus.req_valid && (bus.req_is_load || bus.req_is_store);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = fault ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (bus.resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (state == ST_IDLE);
        bus.mem_is_read  = (state == ST_ACCESS) && ld_q;
        bus.mem_is_write = (state == ST_ACCESS) && st_q;
        bus.resp_valid   = (state == ST_RESP);
    end

    // Memory-side fields only move on a legal accept so they hold across faults and idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            if (accept) begin
                ld_q    <= bus.req_is_load;
                st_q    <= bus.req_is_store;
                fault_q <= fault;
                rd_q    <= bus.req_rd;
                data_q  <= '0;
                if (!fault) begin
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    mode_q  <= bus.req_funct3;
                end
            end
            if (state == ST_ACCESS && ld_q) data_q <= bus.mem_read;
        end
    end

    assign bus.mem_address  = addr_q;
    assign bus.mem_write    = wdata_q;
    assign bus.mem_mode     = mode_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_rd      = rd_q;
    assign bus.resp_is_load = ld_q;
    assign bus.resp_fault   = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a big-endian 1 KiB byte memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_STAGE_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_stage_if #(.ADDR_W(32), .RD_W(5)) bus ();

    mem_stage #(.MEM_BYTES(1024), .ADDR_W(32), .RD_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    logic [9:0] ma;

    always_comb begin
        ma = bus.mem_address[9:0];
        case (bus.mem_mode)
            FUNCT3_B:  bus.mem_read = {{24{mem[ma][7]}}, mem[ma]};
            FUNCT3_BU: bus.mem_read = {24'h0, mem[ma]};
            FUNCT3_H:  bus.mem_read = {{16{mem[ma][7]}}, mem[ma], mem[ma+10'd1]};
            FUNCT3_HU: bus.mem_read = {16'h0, mem[ma], mem[ma+10'd1]};
            default:   bus.mem_read = {mem[ma], mem[ma+10'd1], mem[ma+10'd2], mem[ma+10'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_is_write) begin
            case (bus.mem_mode)
                FUNCT3_B: mem[ma] <= bus.mem_write[7:0];
                FUNCT3_H: begin
                    mem[ma]       <= bus.mem_write[15:8];
                    mem[ma+10'd1] <= bus.mem_write[7:0];
                end
                default: begin
                    mem[ma]       <= bus.mem_write[31:24];
                    mem[ma+10'd1] <= bus.mem_write[23:16];
                    mem[ma+10'd2] <= bus.mem_write[15:8];
                    mem[ma+10'd3] <= bus.mem_write[7:0];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = ld;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_is_load  = 1'b0;
        bus.req_is_store = 1'b0;
    endtask

    // Called #1 after the accept edge; lat counts edges from accept to resp_valid.
    task automatic wait_resp(output int lat, output int strobes);
        lat = 1;
        strobes = 0;
        while (!bus.resp_valid && lat < 20) begin
            if (bus.mem_is_read)  strobes++;
            if (bus.mem_is_write) strobes++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("resp_timeout", {31'h0, bus.resp_valid}, 32'h1);
    endtask

    task automatic finish_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic exp_fault, input logic [31:0] exp_data);
        int lat, strobes;
        issue(ld, st, f3, a, wd, rd);
        wait_resp(lat, strobes);
        chk({tag, "_fault"}, {31'h0, bus.resp_fault}, {31'h0, exp_fault});
        chk({tag, "_data"}, bus.resp_data, exp_data);
        chk({tag, "_rd"}, {27'h0, bus.resp_rd}, {27'h0, rd});
        chk({tag, "_isld"}, {31'h0, bus.resp_is_load}, {31'h0, ld});
        chk({tag, "_lat"}, lat, exp_fault ? 32'd1 : 32'd2);
        chk({tag, "_strobe"}, strobes, exp_fault ? 32'd0 : 32'd1);
        finish_resp();
        chk({tag, "_idle"}, {31'h0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        int lat, strobes;
        bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
        bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_strobes", {30'h0, bus.mem_is_read, bus.mem_is_write}, 32'h0);
        chk("rst_addr", bus.mem_address, 32'h0);
        chk("rst_resp", {bus.resp_data[31:7], bus.resp_rd, bus.resp_is_load, bus.resp_fault}, 32'h0);
        rst = 1'b0;

        // Word round trip and big-endian byte placement
        xact("st_w", 1'b0, 1'b1, FUNCT3_W, 32'h10, 32'hDEADBEEF, 5'd1, 1'b0, 32'h0);
        chk("be_lo", {24'h0, mem[16]}, 32'hDE);
        chk("be_hi", {24'h0, mem[19]}, 32'hEF);
        xact("ld_w", 1'b1, 1'b0, FUNCT3_W, 32'h10, 32'h0, 5'd2, 1'b0, 32'hDEADBEEF);

        // Sign/zero extension
        xact("st_b", 1'b0, 1'b1, FUNCT3_B, 32'h20, 32'h12345680, 5'd0, 1'b0, 32'h0);
        xact("ld_b", 1'b1, 1'b0, FUNCT3_B, 32'h20, 32'h0, 5'd3, 1'b0, 32'hFFFFFF80);
        xact("ld_bu", 1'b1, 1'b0, FUNCT3_BU, 32'h20, 32'h0, 5'd4, 1'b0, 32'h00000080);
        xact("st_h", 1'b0, 1'b1, FUNCT3_H, 32'h22, 32'hAAAA9123, 5'd5, 1'b0, 32'h0);
        xact("ld_h", 1'b1, 1'b0, FUNCT3_H, 32'h22, 32'h0, 5'd6, 1'b0, 32'hFFFF9123);
        xact("ld_hu", 1'b1, 1'b0, FUNCT3_HU, 32'h22, 32'h0, 5'd7, 1'b0, 32'h00009123);

        // Misaligned word
        xact("st_m0", 1'b0, 1'b1, FUNCT3_W, 32'h100, 32'h00010203, 5'd0, 1'b0, 32'h0);
        xact("st_m1", 1'b0, 1'b1, FUNCT3_W, 32'h104, 32'h04050607, 5'd0, 1'b0, 32'h0);
        xact("ld_mis", 1'b1, 1'b0, FUNCT3_W, 32'h102, 32'h0, 5'd8, !MIS_EN,
             MIS_EN ? 32'h02030405 : 32'h0);

        // Range edges and illegal encodings
        xact("st_top", 1'b0, 1'b1, FUNCT3_W, 32'h3FC, 32'h11223344, 5'd0, 1'b0, 32'h0);
        xact("ld_top", 1'b1, 1'b0, FUNCT3_W, 32'h3FC, 32'h0, 5'd9, 1'b0, 32'h11223344);
        xact("ld_last", 1'b1, 1'b0, FUNCT3_BU, 32'h3FF, 32'h0, 5'd10, 1'b0, 32'h44);
        xact("st_oor", 1'b0, 1'b1, FUNCT3_W, 32'h3FE, 32'h5, 5'd11, 1'b1, 32'h0);
        xact("ld_b_oor", 1'b1, 1'b0, FUNCT3_B, 32'h400, 32'h0, 5'd12, 1'b1, 32'h0);
        xact("ld_wrap", 1'b1, 1'b0, FUNCT3_W, 32'hFFFFFFFC, 32'h0, 5'd13, 1'b1, 32'h0);
        xact("st_hu", 1'b0, 1'b1, FUNCT3_HU, 32'h0, 32'h5, 5'd14, 1'b1, 32'h0);
        xact("ld_f011", 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0);
        xact("ldst", 1'b1, 1'b1, FUNCT3_W, 32'h0, 32'h0, 5'd16, 1'b1, 32'h0);

        // Neither load nor store: dropped
        issue(1'b0, 1'b0, FUNCT3_W, 32'h10, 32'h0, 5'd17);
        chk("drop_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("drop_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("drop_strobe", {30'h0, bus.mem_is_read, bus.mem_is_write}, 32'h0);

        // Backpressure
        issue(1'b1, 1'b0, FUNCT3_W, 32'h10, 32'h0, 5'd18);
        wait_resp(lat, strobes);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = FUNCT3_W;
            bus.req_addr = 32'h30; bus.req_wdata = 32'h55; bus.req_rd = 5'd19;
            chk("bp_ready", {31'h0, bus.req_ready}, 32'h0);
            chk("bp_valid", {31'h0, bus.resp_valid}, 32'h1);
            chk("bp_data", bus.resp_data, 32'hDEADBEEF);
            chk("bp_rd", {27'h0, bus.resp_rd}, 32'd18);
            chk("bp_strobe", {30'h0, bus.mem_is_read, bus.mem_is_write}, 32'h0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0;
        finish_resp();
        chk("bp_idle", {31'h0, bus.req_ready}, 32'h1);
        chk("bp_clear", {31'h0, bus.resp_valid}, 32'h0);
        xact("bp_next", 1'b1, 1'b0, FUNCT3_BU, 32'h20, 32'h0, 5'd20, 1'b0, 32'h80);

        // Reset during a store's ACCESS cycle
        issue(1'b0, 1'b1, FUNCT3_W, 32'h40, 32'hCAFEF00D, 5'd21);
        chk("ra_wr", {31'h0, bus.mem_is_write}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ra_strobe", {30'h0, bus.mem_is_read, bus.mem_is_write}, 32'h0);
        chk("ra_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("ra_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("ra_addr", bus.mem_address, 32'h0);
        chk("ra_wdata", bus.mem_write, 32'h0);
        chk("ra_resp", {bus.resp_data[31:7], bus.resp_rd, bus.resp_is_load, bus.resp_fault}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ra_noresp", {31'h0, bus.resp_valid}, 32'h0);
        xact("ra_after", 1'b1, 1'b0, FUNCT3_W, 32'h40, 32'h0, 5'd22, 1'b0, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
